wasm_operand_stack: RTL and testbench

- Parametrised operand stack for the WebAssembly CPU. It replaces the fixed 64-bit stack that the i64 tests run against.
- Supports configurable value width and depth, and a combined pop-then-push operation so unary and binary ops (eqz, add, ...) retire in one cycle.
- Exposes top-of-stack as result/result_empty for the test benches, and raises sticky stack traps.

---
 rtl/wasm_operand_stack.sv | 102 ++++++++++
 tb/tb_wasm_operand_stack.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_operand_stack.sv
// Operand stack for the WebAssembly CPU: pop-then-push in one cycle, sticky traps.
module wasm_operand_stack #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       pop_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [WIDTH-1:0] result,
  output logic             result_empty,
  output logic             full,
  output logic [CNT_W-1:0] depth,
  output logic [3:0]       trap
);

  // One extra bit so sp - pop_n + push never wraps in the range compares.
  localparam int unsigned EXT_W = CNT_W + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] TRAP_NONE      = 4'd0;
  localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
  localparam logic [3:0] TRAP_OVERFLOW  = 4'd2;
  localparam logic [3:0] TRAP_ILLEGAL   = 4'd3;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] sp;
  logic [CNT_W-1:0] sp_next;
  logic [3:0]       trap_q;
  logic [3:0]       trap_next;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [EXT_W-1:0] sp_ext;
  logic [EXT_W-1:0] pop_ext;
  logic [EXT_W-1:0] need_ext;

  // Decode the operation: legality checks in priority order, then the new sp and write slot.
  always_comb begin
    sp_next   = sp;
    trap_next = trap_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    sp_ext    = EXT_W'(sp);
    pop_ext   = EXT_W'(pop_n);
    need_ext  = sp_ext - pop_ext + EXT_W'(push);
    if (op_valid && (trap_q == TRAP_NONE)) begin
      if (pop_n == 2'd3) begin
        trap_next = TRAP_ILLEGAL;
      end else if (pop_ext > sp_ext) begin
        trap_next = TRAP_UNDERFLOW;
      end else if (need_ext > EXT_W'(DEPTH)) begin
        trap_next = TRAP_OVERFLOW;
      end else begin
        sp_next = CNT_W'(need_ext);
        wr_en   = push;
        wr_idx  = IDX_W'(sp_ext - pop_ext);
      end
    end
  end

  // Stack pointer and sticky trap register; reset wins over any op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp     <= '0;
      trap_q <= TRAP_NONE;
    end else begin
      sp     <= sp_next;
      trap_q <= trap_next;
    end
  end

  // Value storage; contents are don't-care after reset, so no clear.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Top-of-stack views, zero when the slot is not populated.
  always_comb begin
    top    = '0;
    second = '0;
    if (sp != '0) begin
      top = mem[IDX_W'(sp - CNT_W'(1))];
    end
    if (sp >= CNT_W'(2)) begin
      second = mem[IDX_W'(sp - CNT_W'(2))];
    end
  end

  assign result       = top;
  assign result_empty = (sp == '0);
  assign full         = (sp == CNT_W'(DEPTH));
  assign depth        = sp;
  assign trap         = trap_q;

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Scoreboard bench for wasm_operand_stack: 64-bit and 32-bit builds, both DEPTH=4.
module tb_wasm_operand_stack;

  typedef struct {
    int          sel;
    logic [2:0]  depth;
    logic [63:0] top;
    logic [63:0] second;
    logic        empty;
    logic        full;
    logic [3:0]  trap;
  } exp_t;

  logic        clk;
  logic        reset;

  logic        op_valid64, push64;
  logic [1:0]  pop_n64;
  logic [63:0] data64, top64, second64, result64;
  logic        empty64, full64;
  logic [2:0]  depth64;
  logic [3:0]  trap64;

  logic        op_valid32, push32;
  logic [1:0]  pop_n32;
  logic [31:0] data32, top32, second32, result32;
  logic        empty32, full32;
  logic [2:0]  depth32;
  logic [3:0]  trap32;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  wasm_operand_stack #(.WIDTH(64), .DEPTH(4)) u_dut64 (
    .clk(clk), .reset(reset), .op_valid(op_valid64), .pop_n(pop_n64), .push(push64),
    .push_data(data64), .top(top64), .second(second64), .result(result64),
    .result_empty(empty64), .full(full64), .depth(depth64), .trap(trap64)
  );

  wasm_operand_stack #(.WIDTH(32), .DEPTH(4)) u_dut32 (
    .clk(clk), .reset(reset), .op_valid(op_valid32), .pop_n(pop_n32), .push(push32),
    .push_data(data32), .top(top32), .second(second32), .result(result32),
    .result_empty(empty32), .full(full32), .depth(depth32), .trap(trap32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT state away from the active edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.sel == 0) begin
        check(nm, "depth",  64'(depth64),  64'(e.depth));
        check(nm, "top",    top64,         e.top);
        check(nm, "result", result64,      e.top);
        check(nm, "second", second64,      e.second);
        check(nm, "empty",  64'(empty64),  64'(e.empty));
        check(nm, "full",   64'(full64),   64'(e.full));
        check(nm, "trap",   64'(trap64),   64'(e.trap));
      end else begin
        check(nm, "depth",  64'(depth32),  64'(e.depth));
        check(nm, "top",    64'(top32),    e.top);
        check(nm, "result", 64'(result32), e.top);
        check(nm, "second", 64'(second32), e.second);
        check(nm, "empty",  64'(empty32),  64'(e.empty));
        check(nm, "full",   64'(full32),   64'(e.full));
        check(nm, "trap",   64'(trap32),   64'(e.trap));
      end
    end
  end

  task automatic expect_st(input int sel, input string nm, input logic [2:0] d,
                           input logic [63:0] t, input logic [63:0] s, input logic em,
                           input logic fu, input logic [3:0] tr);
    exp_t e;
    e.sel = sel; e.depth = d; e.top = t; e.second = s;
    e.empty = em; e.full = fu; e.trap = tr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Issue one op; called and returns 1 time unit after a rising edge.
  task automatic op(input int sel, input logic [1:0] p, input logic ps, input logic [63:0] d);
    if (sel == 0) begin
      op_valid64 = 1'b1; pop_n64 = p; push64 = ps; data64 = d;
    end else begin
      op_valid32 = 1'b1; pop_n32 = p; push32 = ps; data32 = d[31:0];
    end
    @(posedge clk); #1;
    op_valid64 = 1'b0; pop_n64 = 2'd0; push64 = 1'b0; data64 = '0;
    op_valid32 = 1'b0; pop_n32 = 2'd0; push32 = 1'b0; data32 = '0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ones;
    ones  = '1;
    reset = 1'b0;
    op_valid64 = 1'b0; pop_n64 = 2'd0; push64 = 1'b0; data64 = '0;
    op_valid32 = 1'b0; pop_n32 = 2'd0; push32 = 1'b0; data32 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    expect_st(0, "reset64", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);
    expect_st(1, "reset32", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);

    // op_valid low: inputs ignored
    push64 = 1'b1; data64 = 64'h55; pop_n64 = 2'd1;
    @(posedge clk); #1;
    push64 = 1'b0; data64 = '0; pop_n64 = 2'd0;
    expect_st(0, "idle", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);

    // eqz-style replace of top
    op(0, 2'd0, 1'b1, 64'd0);
    expect_st(0, "push0", 3'd1, 64'd0, 64'd0, 1'b0, 1'b0, 4'd0);
    op(0, 2'd1, 1'b1, 64'd1);
    expect_st(0, "eqz", 3'd1, 64'd1, 64'd0, 1'b0, 1'b0, 4'd0);

    // fill, then overflow trap stays sticky
    do_reset(1);
    op(0, 2'd0, 1'b1, 64'd5);
    op(0, 2'd0, 1'b1, 64'd6);
    op(0, 2'd0, 1'b1, 64'd7);
    op(0, 2'd0, 1'b1, 64'd8);
    expect_st(0, "fill", 3'd4, 64'd8, 64'd7, 1'b0, 1'b1, 4'd0);
    op(0, 2'd0, 1'b1, 64'd9);
    expect_st(0, "ovf", 3'd4, 64'd8, 64'd7, 1'b0, 1'b1, 4'd2);
    op(0, 2'd0, 1'b1, 64'd10);
    expect_st(0, "ovf_sticky", 3'd4, 64'd8, 64'd7, 1'b0, 1'b1, 4'd2);
    op(0, 2'd1, 1'b0, 64'd0);
    expect_st(0, "ovf_freeze", 3'd4, 64'd8, 64'd7, 1'b0, 1'b1, 4'd2);
    op(0, 2'd3, 1'b0, 64'd0);
    expect_st(0, "first_kept", 3'd4, 64'd8, 64'd7, 1'b0, 1'b1, 4'd2);

    // binary op, drain, underflow
    do_reset(1);
    expect_st(0, "rst_clr", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);
    op(0, 2'd0, 1'b1, 64'd3);
    op(0, 2'd0, 1'b1, 64'd4);
    expect_st(0, "two", 3'd2, 64'd4, 64'd3, 1'b0, 1'b0, 4'd0);
    op(0, 2'd2, 1'b1, 64'd7);
    expect_st(0, "binop", 3'd1, 64'd7, 64'd0, 1'b0, 1'b0, 4'd0);
    op(0, 2'd1, 1'b0, 64'd0);
    expect_st(0, "drain", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);
    op(0, 2'd1, 1'b0, 64'd0);
    expect_st(0, "udf", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd1);

    // illegal pop_n, then reset clears it
    do_reset(1);
    op(0, 2'd0, 1'b1, 64'd1);
    op(0, 2'd0, 1'b1, 64'd2);
    op(0, 2'd3, 1'b0, 64'd0);
    expect_st(0, "illegal", 3'd2, 64'd2, 64'd1, 1'b0, 1'b0, 4'd3);
    do_reset(1);
    expect_st(0, "illegal_rst", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);

    // reset beats op_valid in the same cycle
    reset = 1'b0;
    op(0, 2'd0, 1'b1, 64'h77);
    reset = 1'b1;
    expect_st(0, "rst_prio", 3'd0, 64'd0, 64'd0, 1'b1, 1'b0, 4'd0);

    // full boundary: replace-top and binary op are legal when full
    op(0, 2'd0, 1'b1, 64'd5);
    op(0, 2'd0, 1'b1, 64'd6);
    op(0, 2'd0, 1'b1, 64'd7);
    op(0, 2'd0, 1'b1, 64'd8);
    op(0, 2'd1, 1'b1, 64'hAA);
    expect_st(0, "full_unary", 3'd4, 64'hAA, 64'd7, 1'b0, 1'b1, 4'd0);
    op(0, 2'd2, 1'b1, ones);
    expect_st(0, "full_binop", 3'd3, ones, 64'd6, 1'b0, 1'b0, 4'd0);

    // 32-bit build: same binary op on a full stack
    op(1, 2'd0, 1'b1, 64'd1);
    op(1, 2'd0, 1'b1, 64'd2);
    op(1, 2'd0, 1'b1, 64'd3);
    op(1, 2'd0, 1'b1, 64'd4);
    expect_st(1, "fill32", 3'd4, 64'd4, 64'd3, 1'b0, 1'b1, 4'd0);
    op(1, 2'd2, 1'b1, 64'hFFFF_FFFF);
    expect_st(1, "binop32", 3'd3, 64'hFFFF_FFFF, 64'd2, 1'b0, 1'b0, 4'd0);

    // let the monitor drain, bounded
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
